// File: rtl/sb_param_shadow_cfg.sv
// Switch-block routing with a serially loaded shadow configuration chain.
// A committed copy of the chain drives the track muxes, so reloading never glitches routing.
module sb_param_shadow_cfg #(
  parameter int unsigned CHAN_W  = 5,
  parameter int unsigned NUM_PIN = 4
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic [4*CHAN_W-1:0]   chan_in,
  input  logic [4*NUM_PIN-1:0]  grid_pin_in,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_commit,
  output logic [4*CHAN_W-1:0]   chan_out,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int unsigned M     = 4 + NUM_PIN;
  localparam int unsigned SEL_W = $clog2(M + 1);
  localparam int unsigned L     = 4 * CHAN_W * SEL_W;
  localparam int unsigned CNT_W = $clog2(L + 1);
  localparam logic [CNT_W-1:0] CountFull = CNT_W'(L);

  logic [L-1:0]     shadow_q;
  logic [L-1:0]     active_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  // Commit takes priority over shifting; a premature commit only flags the error.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else if (ccff_commit) begin
      if (count_q == CountFull) begin
        active_q <= shadow_q;
        count_q  <= '0;
      end else begin
        err_q <= 1'b1;
      end
    end else if (ccff_en) begin
      shadow_q <= {shadow_q[L-2:0], ccff_head};
      if (count_q != CountFull) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign ccff_tail = shadow_q[L-1];
  assign cfg_done  = (count_q == CountFull);
  assign cfg_err   = err_q;

  always_comb begin
    chan_out = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < CHAN_W; t++) begin
        int unsigned sel;
        sel = int'(active_q[(s*CHAN_W+t)*SEL_W +: SEL_W]);
        if (sel == 0) begin
          chan_out[s*CHAN_W+t] = chan_in[((s+2)%4)*CHAN_W+t];
        end else if (sel == 1) begin
          chan_out[s*CHAN_W+t] = chan_in[((s+1)%4)*CHAN_W+t];
        end else if (sel == 2) begin
          chan_out[s*CHAN_W+t] = chan_in[((s+3)%4)*CHAN_W+t];
        end else if (sel == 3) begin
          chan_out[s*CHAN_W+t] = chan_in[((s+2)%4)*CHAN_W+((t+1)%CHAN_W)];
        end else if (sel < M) begin
          chan_out[s*CHAN_W+t] = grid_pin_in[s*NUM_PIN+int'(sel)-4];
        end
      end
    end
  end

endmodule

// File: doc/sb_param_shadow_cfg.md
SB_PARAM_SHADOW_CFG -- requirements
Module: sb_param_shadow_cfg

Interface
REQ-001 Parameter CHAN_W, default 5, meaning tracks per side.
REQ-002 Parameter NUM_PIN, default 4, meaning grid pins entering each side.
REQ-003 Derived constants (not overridable): M = 4+NUM_PIN (mux size); SEL_W = clog2(M+1); L = 4*CHAN_W*SEL_W (chain length).
REQ-004 prog_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 pReset  input  1  reset; synchronous, active-high.
REQ-006 chan_in  input  4*CHAN_W  incoming tracks; side s track t at bit s*CHAN_W+t; side 0=top, 1=right, 2=bottom, 3=left.
REQ-007 grid_pin_in  input  4*NUM_PIN  grid pins; side s pin p at bit s*NUM_PIN+p.
REQ-008 ccff_head  input  1  serial configuration data in.
REQ-009 ccff_en  input  1  shift-enable for the configuration chain.
REQ-010 ccff_commit  input  1  single-cycle pulse; copies shadow chain to active configuration.
REQ-011 chan_out  output  4*CHAN_W  outgoing tracks, same packing as chan_in.
REQ-012 ccff_tail  output  1  serial configuration data out (chain bit L-1, registered).
REQ-013 cfg_done  output  1  high when exactly L or more shifts accumulated since last reset/commit.
REQ-014 cfg_err  output  1  sticky; premature commit detected.

Function
REQ-015 Each output chan_out[s][t] is a mux selected by active field F(s,t), field index f = s*CHAN_W+t, bits [f*SEL_W +: SEL_W], LSB at lower index.
REQ-016 Mux input order: sel 0 = chan_in[(s+2)%4][t]; 1 = chan_in[(s+1)%4][t]; 2 = chan_in[(s+3)%4][t]; 3 = chan_in[(s+2)%4][(t+1)%CHAN_W]; 4+p = grid_pin_in[s][p], p in 0..NUM_PIN-1.
REQ-017 Select value >= M drives chan_out[s][t] = 0.
REQ-018 Datapath is combinational from chan_in/grid_pin_in/active config to chan_out; zero-cycle latency.
REQ-019 Shadow chain: L-bit register; when ccff_en=1 and ccff_commit=0, bit 0 <= ccff_head, bit k <= bit k-1; ccff_tail <= shadow bit L-1 value after shift (ccff_tail equals shadow[L-1]).
REQ-020 First bit shifted after reset reaches shadow[L-1] (MSB of last field) after L shifts.
REQ-021 Shift counter: increments on each shift, saturates at L; cfg_done = (count == L).
REQ-022 ccff_commit=1 with count == L: active <= shadow, count <= 0 next cycle; shadow contents retained.
REQ-023 ccff_commit=1 with count < L: active unchanged, count unchanged, cfg_err <= 1.
REQ-024 ccff_commit and ccff_en both 1: commit evaluated per REQ-022/023, shift suppressed that cycle.
REQ-025 Shifting while count == L: chain continues shifting, count stays L, cfg_done stays 1.
REQ-026 cfg_err clears only on pReset.
REQ-027 Active configuration changes only via successful commit; shifting never disturbs chan_out.

Reset
REQ-028 pReset=1 at a rising edge: shadow=0, active=0, count=0, ccff_tail=0, cfg_done=0, cfg_err=0; overrides ccff_en/ccff_commit that cycle.
REQ-029 With active=0 all outputs route straight across (sel 0); reset mid-shift discards partial load.

Verification (CHAN_W=5, NUM_PIN=4: M=8, SEL_W=4, L=80)
REQ-030 Reset, chan_in top[2]=1 only -> chan_out bottom[2]=1, all other chan_out 0, cfg_done=0, cfg_err=0.
REQ-031 Shift 80 bits making every field 4'd4, commit -> cfg_done=1 before commit, 0 after; grid_pin_in side s pin0 toggling appears on all 5 tracks of side s same cycle.
REQ-032 Load field f=0 (top track0) = 4'd9, others 0, commit -> chan_out top[0]=0 for any inputs; field=4'd3 -> top[0] follows chan_in bottom[1].
REQ-033 Shift 79 bits, commit -> cfg_err=1 next cycle, chan_out unchanged, count stays 79; one more shift then commit succeeds, cfg_err remains 1.
REQ-034 Shift pattern A (80 bits) then pattern B (80 bits) -> ccff_tail during B shifts reproduces A bit-for-bit, first A bit visible after shift 80.
REQ-035 ccff_en=1 and ccff_commit=1 same cycle at count 80 -> commit succeeds, shadow not shifted, count=0.
